// File: rtl/maze_walker_pkg.sv
// Shared types and direction helpers for the wall-follower maze walker.
// Directions: 0 DOWN (row+1), 1 LEFT (col-1), 2 UP (row-1), 3 RIGHT (col+1).
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_INIT    = 4'd1,
    S_PROBE_S = 4'd2,
    S_EVAL_S  = 4'd3,
    S_PROBE_F = 4'd4,
    S_EVAL_F  = 4'd5,
    S_PROBE_O = 4'd6,
    S_EVAL_O  = 4'd7,
    S_STEP    = 4'd8,
    S_DONE    = 4'd9,
    S_FAIL    = 4'd10
  } state_t;

  function automatic dir_t turn_right(input dir_t d);
    return dir_t'(d + 2'd1);
  endfunction

  function automatic dir_t turn_left(input dir_t d);
    return dir_t'(d - 2'd1);
  endfunction

  function automatic dir_t turn_back(input dir_t d);
    return dir_t'(d + 2'd2);
  endfunction

endpackage

// File: rtl/maze_walker_neighbour.sv
// Combinational neighbour address: one cell from (row, col) in direction dir.
// o_out_of_range flags a step that would wrap past either edge of the maze.
module maze_neighbour
  import maze_pkg::*;
#(
  parameter int MAZE_W = 6
) (
  input  dir_t              i_dir,
  input  logic [MAZE_W-1:0] i_row,
  input  logic [MAZE_W-1:0] i_col,
  output logic [MAZE_W-1:0] o_row,
  output logic [MAZE_W-1:0] o_col,
  output logic              o_out_of_range
);

  localparam logic [MAZE_W-1:0] LP_ONE  = MAZE_W'(1);
  localparam logic [MAZE_W-1:0] LP_EDGE = '1;

  always_comb begin
    o_row          = i_row;
    o_col          = i_col;
    o_out_of_range = 1'b0;
    unique case (i_dir)
      DIR_DOWN: begin
        o_row          = i_row + LP_ONE;
        o_out_of_range = (i_row == LP_EDGE);
      end
      DIR_LEFT: begin
        o_col          = i_col - LP_ONE;
        o_out_of_range = (i_col == '0);
      end
      DIR_UP: begin
        o_row          = i_row - LP_ONE;
        o_out_of_range = (i_row == '0);
      end
      DIR_RIGHT: begin
        o_col          = i_col + LP_ONE;
        o_out_of_range = (i_col == LP_EDGE);
      end
      default: o_out_of_range = 1'b0;
    endcase
  end

endmodule

// File: rtl/maze_walker.sv
// Wall-follower maze solver driving an external 1-cycle-latency cell memory.
// Handshake: i_start is taken only while o_busy=0; o_done/o_fail hold until the next accepted start.
module maze_walker
  import maze_pkg::*;
#(
  parameter int MAZE_W    = 6,
  parameter int STEP_W    = 16,
  parameter int MAX_STEPS = (1 << STEP_W) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_hand_sel,
  input  logic [MAZE_W-1:0] i_starting_row,
  input  logic [MAZE_W-1:0] i_starting_col,
  input  logic              i_maze_in,
  output logic [MAZE_W-1:0] o_row,
  output logic [MAZE_W-1:0] o_col,
  output logic              o_maze_oe,
  output logic              o_maze_we,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_fail,
  output logic [STEP_W-1:0] o_step_count,
  output state_t            o_state
);

  localparam logic [MAZE_W-1:0] LP_EDGE  = '1;
  localparam logic [STEP_W:0]   LP_LIMIT = (STEP_W + 1)'(MAX_STEPS);

  state_t              r_state;
  dir_t                r_dir;
  logic                r_hand;
  logic [MAZE_W-1:0]   r_row, r_col;
  logic [MAZE_W-1:0]   r_cand_row, r_cand_col;
  logic                r_oor;
  logic [MAZE_W-1:0]   r_o_row, r_o_col;
  logic                r_oe, r_we, r_busy, r_done, r_fail;
  logic [STEP_W-1:0]   r_step;

  dir_t                w_pref_dir, w_other_dir, w_nb_dir;
  logic [MAZE_W-1:0]   w_nb_row, w_nb_col;
  logic                w_nb_oor;
  logic                w_free;
  logic                w_border;
  logic [STEP_W:0]     w_step_next;

  assign w_pref_dir  = r_hand ? turn_left(r_dir)  : turn_right(r_dir);
  assign w_other_dir = r_hand ? turn_right(r_dir) : turn_left(r_dir);
  assign w_free      = ~i_maze_in & ~r_oor;
  assign w_border    = (r_row == '0) || (r_row == LP_EDGE) || (r_col == '0) || (r_col == LP_EDGE);
  assign w_step_next = {1'b0, r_step} + {{STEP_W{1'b0}}, 1'b1};

  // The neighbour needed is always the one for the state being entered next.
  always_comb begin
    w_nb_dir = w_pref_dir;
    case (r_state)
      S_EVAL_S: w_nb_dir = r_dir;
      S_EVAL_F: w_nb_dir = w_other_dir;
      S_EVAL_O: w_nb_dir = turn_back(r_dir);
      default:  w_nb_dir = w_pref_dir;
    endcase
  end

  maze_neighbour #(.MAZE_W(MAZE_W)) u_neighbour (
    .i_dir          (w_nb_dir),
    .i_row          (r_row),
    .i_col          (r_col),
    .o_row          (w_nb_row),
    .o_col          (w_nb_col),
    .o_out_of_range (w_nb_oor)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_dir      <= DIR_DOWN;
      r_hand     <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_cand_row <= '0;
      r_cand_col <= '0;
      r_oor      <= 1'b0;
      r_o_row    <= '0;
      r_o_col    <= '0;
      r_oe       <= 1'b0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      r_step     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (i_start) begin
            r_state <= S_INIT;
            r_hand  <= i_hand_sel;
            r_dir   <= DIR_DOWN;
            r_row   <= i_starting_row;
            r_col   <= i_starting_col;
            r_o_row <= i_starting_row;
            r_o_col <= i_starting_col;
            r_we    <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
            r_step  <= '0;
          end
        end
        S_INIT: begin
          r_we       <= 1'b0;
          r_state    <= S_PROBE_S;
          r_o_row    <= w_nb_row;
          r_o_col    <= w_nb_col;
          r_cand_row <= w_nb_row;
          r_cand_col <= w_nb_col;
          r_oor      <= w_nb_oor;
          r_oe       <= ~w_nb_oor;
        end
        S_PROBE_S, S_PROBE_F, S_PROBE_O: begin
          r_oe    <= 1'b0;
          r_o_row <= r_row;
          r_o_col <= r_col;
          r_state <= (r_state == S_PROBE_S) ? S_EVAL_S :
                     (r_state == S_PROBE_F) ? S_EVAL_F : S_EVAL_O;
        end
        S_EVAL_S, S_EVAL_F: begin
          if (w_free) begin
            if (r_state == S_EVAL_S) r_dir <= w_pref_dir;
            r_row   <= r_cand_row;
            r_col   <= r_cand_col;
            r_o_row <= r_cand_row;
            r_o_col <= r_cand_col;
            r_we    <= 1'b1;
            r_state <= S_STEP;
          end else begin
            r_state    <= (r_state == S_EVAL_S) ? S_PROBE_F : S_PROBE_O;
            r_o_row    <= w_nb_row;
            r_o_col    <= w_nb_col;
            r_cand_row <= w_nb_row;
            r_cand_col <= w_nb_col;
            r_oor      <= w_nb_oor;
            r_oe       <= ~w_nb_oor;
          end
        end
        S_EVAL_O: begin
          // Dead end: the reverse cell is taken without a probe.
          r_dir   <= w_free ? w_other_dir : turn_back(r_dir);
          r_row   <= w_free ? r_cand_row : w_nb_row;
          r_col   <= w_free ? r_cand_col : w_nb_col;
          r_o_row <= w_free ? r_cand_row : w_nb_row;
          r_o_col <= w_free ? r_cand_col : w_nb_col;
          r_we    <= 1'b1;
          r_state <= S_STEP;
        end
        S_STEP: begin
          r_we   <= 1'b0;
          r_step <= w_step_next[STEP_W-1:0];
          if (w_border) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_step_next == LP_LIMIT) begin
            r_state <= S_FAIL;
            r_fail  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state    <= S_PROBE_S;
            r_o_row    <= w_nb_row;
            r_o_col    <= w_nb_col;
            r_cand_row <= w_nb_row;
            r_cand_col <= w_nb_col;
            r_oor      <= w_nb_oor;
            r_oe       <= ~w_nb_oor;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_row        = r_o_row;
  assign o_col        = r_o_col;
  assign o_maze_oe    = r_oe;
  assign o_maze_we    = r_we;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_fail       = r_fail;
  assign o_step_count = r_step;
  assign o_state      = r_state;

endmodule

// File: tb/tb_maze_walker.sv
// Bench for maze_walker: a walk model over a wall map predicts the write trace,
// per-move cycle cost, final step count and done/fail outcome.
module tb_maze_walker;
  import maze_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic hand = 1'b0;
  logic [5:0] srow = '0, scol = '0;
  logic maze_in_a = 1'b0, maze_in_b = 1'b0;
  logic [5:0] row_a, col_a, row_b, col_b;
  logic oe_a, we_a, busy_a, done_a, fail_a;
  logic oe_b, we_b, busy_b, done_b, fail_b;
  logic [15:0] step_a, step_b;
  state_t state_a, state_b;

  bit wall [0:63][0:63];
  logic [11:0] exp_q[$];
  int          exp_gap_q[$];
  logic [11:0] got_q[$];
  int          got_gap_q[$];
  logic [11:0] tr0[$];
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  maze_walker dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start_a), .i_hand_sel(hand),
    .i_starting_row(srow), .i_starting_col(scol), .i_maze_in(maze_in_a),
    .o_row(row_a), .o_col(col_a), .o_maze_oe(oe_a), .o_maze_we(we_a),
    .o_busy(busy_a), .o_done(done_a), .o_fail(fail_a),
    .o_step_count(step_a), .o_state(state_a)
  );

  maze_walker #(.MAX_STEPS(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start_b), .i_hand_sel(hand),
    .i_starting_row(srow), .i_starting_col(scol), .i_maze_in(maze_in_b),
    .o_row(row_b), .o_col(col_b), .o_maze_oe(oe_b), .o_maze_we(we_b),
    .o_busy(busy_b), .o_done(done_b), .o_fail(fail_b),
    .o_step_count(step_b), .o_state(state_b)
  );

  // Synchronous cell memories, one read port per walker.
  always @(posedge clk) begin
    maze_in_a <= oe_a ? wall[row_a][col_a] : 1'b0;
    maze_in_b <= oe_b ? wall[row_b][col_b] : 1'b0;
  end

  function automatic logic [11:0] pack(input int r, input int c);
    logic [5:0] pr, pc;
    pr = r[5:0];
    pc = c[5:0];
    return {pr, pc};
  endfunction

  function automatic bit is_wall(input int r, input int c);
    if (r < 0 || r > 63 || c < 0 || c > 63) return 1'b1;
    return wall[r][c];
  endfunction

  task automatic fill(input bit v);
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++) wall[r][c] = v;
  endtask

  // Wall follower on a grid: try side, front, other side, else turn around.
  task automatic model_walk(input int sr, input int sc, input bit hnd, input int limit,
                            output int steps, output bit fin_done);
    int dr[4] = '{1, 0, -1, 0};
    int dc[4] = '{0, -1, 0, 1};
    int order[3];
    int r, c, d, nd, k;
    r = sr; c = sc; d = 0; steps = 0; fin_done = 1'b0;
    exp_q.delete();
    exp_gap_q.delete();
    exp_q.push_back(pack(r, c));
    while (steps < limit) begin
      order[0] = hnd ? (d + 3) % 4 : (d + 1) % 4;
      order[1] = d;
      order[2] = hnd ? (d + 1) % 4 : (d + 3) % 4;
      nd = (d + 2) % 4;
      k = 3;
      for (int i = 2; i >= 0; i--)
        if (!is_wall(r + dr[order[i]], c + dc[order[i]])) begin
          nd = order[i];
          k = i;
        end
      d = nd;
      r = (r + dr[d] + 64) % 64;
      c = (c + dc[d] + 64) % 64;
      steps++;
      exp_q.push_back(pack(r, c));
      exp_gap_q.push_back(k >= 2 ? 7 : 3 + 2 * k);
      if (r == 0 || r == 63 || c == 0 || c == 63) begin
        fin_done = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_walk(input string name, input bit which, input int sr, input int sc,
                          input bit hnd, input int limit, input int budget, input bit poke);
    int exp_steps, last_cyc, end_cyc, n_both, n_bad, cur_r, cur_c, dr, dc, mism, n_we;
    bit exp_done, fin;
    logic s_we, s_oe, s_busy, s_done, s_fail;
    logic [5:0] s_row, s_col;
    logic [15:0] s_step, hold_step;
    model_walk(sr, sc, hnd, limit, exp_steps, exp_done);
    got_q.delete();
    got_gap_q.delete();
    @(negedge clk);
    hand = hnd; srow = 6'(sr); scol = 6'(sc);
    if (which) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    hand = ~hnd; srow = 6'($urandom); scol = 6'($urandom);
    last_cyc = 0; end_cyc = 0; n_both = 0; n_bad = 0; fin = 1'b0;
    cur_r = sr; cur_c = sc;
    s_busy = 1'b0; s_done = 1'b0; s_fail = 1'b0; s_step = '0;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      if (cyc > 0) @(negedge clk);
      s_we   = which ? we_b   : we_a;
      s_oe   = which ? oe_b   : oe_a;
      s_busy = which ? busy_b : busy_a;
      s_done = which ? done_b : done_a;
      s_fail = which ? fail_b : fail_a;
      s_row  = which ? row_b  : row_a;
      s_col  = which ? col_b  : col_a;
      s_step = which ? step_b : step_a;
      if (cyc == 0) begin
        n_tests++;
        if (s_we !== 1'b1 || s_busy !== 1'b1 || s_done !== 1'b0 || s_fail !== 1'b0 || s_step !== 16'd0) begin
          n_fail++;
          $display("FAIL %s init: we=%b busy=%b done=%b fail=%b step=%0d, want we=1 busy=1 done=0 fail=0 step=0",
                   name, s_we, s_busy, s_done, s_fail, s_step);
        end
      end
      if (s_we === 1'b1) begin
        got_q.push_back({s_row, s_col});
        if (cyc > 0) got_gap_q.push_back(cyc - last_cyc);
        last_cyc = cyc;
        cur_r = int'(s_row);
        cur_c = int'(s_col);
      end
      if (s_oe === 1'b1) begin
        if (s_we === 1'b1) n_both++;
        dr = int'(s_row) - cur_r;
        dc = int'(s_col) - cur_c;
        if (dr * dr + dc * dc != 1) n_bad++;
      end
      if (poke && cyc == 2) begin
        srow = 6'd30; scol = 6'd30; hand = ~hnd;
        if (which) start_b = 1'b1; else start_a = 1'b1;
      end
      if (poke && cyc == 3) begin
        start_a = 1'b0; start_b = 1'b0;
      end
      if (s_done === 1'b1 || s_fail === 1'b1) begin
        fin = 1'b1;
        end_cyc = cyc;
      end
    end
    start_a = 1'b0; start_b = 1'b0;
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s timeout: no done/fail within %0d cycles", name, budget);
    end
    n_tests++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s trace_len: got %0d writes, want %0d", name, got_q.size(), exp_q.size());
    end else begin
      mism = -1;
      foreach (exp_q[i]) if (got_q[i] !== exp_q[i] && mism < 0) mism = i;
      if (mism >= 0) begin
        n_fail++;
        $display("FAIL %s trace[%0d]: got (%0d,%0d), want (%0d,%0d)", name, mism,
                 got_q[mism][11:6], got_q[mism][5:0], exp_q[mism][11:6], exp_q[mism][5:0]);
      end
    end
    n_tests++;
    mism = -1;
    if (got_gap_q.size() != exp_gap_q.size()) mism = 0;
    else foreach (exp_gap_q[i]) if (got_gap_q[i] != exp_gap_q[i] && mism < 0) mism = i;
    if (mism >= 0) begin
      n_fail++;
      $display("FAIL %s move_cycles[%0d]: got %0d, want %0d (counts %0d/%0d)", name, mism,
               (mism < got_gap_q.size()) ? got_gap_q[mism] : -1,
               (mism < exp_gap_q.size()) ? exp_gap_q[mism] : -1, got_gap_q.size(), exp_gap_q.size());
    end
    n_tests++;
    if (s_step !== 16'(exp_steps) || s_done !== exp_done || s_fail !== !exp_done || s_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result: step=%0d done=%b fail=%b busy=%b, want step=%0d done=%b fail=%b busy=0",
               name, s_step, s_done, s_fail, s_busy, exp_steps, exp_done, !exp_done);
    end
    n_tests++;
    if (end_cyc != last_cyc + 1) begin
      n_fail++;
      $display("FAIL %s end_timing: flag at cycle %0d, want %0d", name, end_cyc, last_cyc + 1);
    end
    n_tests++;
    if (n_both != 0 || n_bad != 0) begin
      n_fail++;
      $display("FAIL %s probes: oe+we overlaps=%0d non-adjacent reads=%0d, want 0 0", name, n_both, n_bad);
    end
    hold_step = s_step;
    n_we = 0;
    repeat (3) begin
      @(negedge clk);
      if ((which ? we_b : we_a) === 1'b1) n_we++;
    end
    n_tests++;
    if ((which ? done_b : done_a) !== exp_done || (which ? fail_b : fail_a) !== !exp_done ||
        (which ? step_b : step_a) !== hold_step || n_we != 0) begin
      n_fail++;
      $display("FAIL %s hold: done=%b fail=%b step=%0d writes=%0d, want done=%b fail=%b step=%0d writes=0",
               name, which ? done_b : done_a, which ? fail_b : fail_a, which ? step_b : step_a,
               n_we, exp_done, !exp_done, hold_step);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({row_a, col_a, oe_a, we_a, busy_a, done_a, fail_a, step_a} !== '0 || state_a !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_a: row=%0d col=%0d oe=%b we=%b busy=%b done=%b fail=%b step=%0d, want all 0",
               row_a, col_a, oe_a, we_a, busy_a, done_a, fail_a, step_a);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({row_b, col_b, oe_b, we_b, busy_b, done_b, fail_b, step_b} !== '0 || state_b !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_b: row=%0d col=%0d oe=%b we=%b busy=%b done=%b fail=%b step=%0d, want all 0",
               row_b, col_b, oe_b, we_b, busy_b, done_b, fail_b, step_b);
    end
  endtask

  task automatic build_corridor();
    fill(1'b1);
    for (int r = 1; r < 64; r++) wall[r][5] = 1'b0;
  endtask

  task automatic test_corridor();
    build_corridor();
    run_walk("corridor", 1'b0, 1, 5, 1'b0, 65535, 400, 1'b1);
  endtask

  task automatic test_eval_o();
    fill(1'b1);
    for (int c = 10; c < 64; c++) wall[10][c] = 1'b0;
    run_walk("eval_o", 1'b0, 10, 10, 1'b0, 65535, 400, 1'b0);
    n_tests++;
    if (got_q.size() < 2 || got_gap_q.size() < 1 || got_q[1] !== pack(10, 11) || got_gap_q[0] != 7) begin
      n_fail++;
      $display("FAIL eval_o first_move: writes=%0d, want second write (10,11) after 7 cycles", got_q.size());
    end
  endtask

  task automatic test_border_start();
    fill(1'b0);
    run_walk("border_rh", 1'b0, 0, 7, 1'b0, 65535, 40, 1'b0);
    run_walk("border_lh", 1'b0, 0, 7, 1'b1, 65535, 40, 1'b0);
  endtask

  task automatic test_wrap();
    fill(1'b0);
    wall[63][6] = 1'b1;
    run_walk("wrap_front", 1'b0, 63, 7, 1'b0, 65535, 40, 1'b0);
  endtask

  task automatic test_fail_limit();
    fill(1'b1);
    for (int r = 20; r < 23; r++)
      for (int c = 20; c < 23; c++) wall[r][c] = 1'b0;
    run_walk("room_limit", 1'b1, 21, 21, 1'b0, 20, 200, 1'b0);
  endtask

  // Maze symmetric about column 31, exits only through rows 0 and 63.
  task automatic gen_sym_maze(output int sr, output bit ok);
    int steps;
    bit fin;
    ok = 1'b0;
    sr = 32;
    for (int attempt = 0; attempt < 500 && !ok; attempt++) begin
      for (int r = 0; r < 64; r++)
        for (int c = 0; c < 64; c++) begin
          if (c == 0 || c >= 62)      wall[r][c] = 1'b1;
          else if (r == 0 || r == 63) wall[r][c] = 1'b0;
          else if (c <= 31)           wall[r][c] = ($urandom_range(0, 99) < 28);
          else                        wall[r][c] = wall[r][62 - c];
        end
      sr = $urandom_range(5, 58);
      wall[sr][31] = 1'b0;
      model_walk(sr, 31, 1'b0, 600, steps, fin);
      if (fin && steps > 3) ok = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    int sr, mism;
    bit ok;
    for (int round = 0; round < 3; round++) begin
      gen_sym_maze(sr, ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL maze_gen: no solvable symmetric maze found");
      end
      run_walk("b2b_rh", 1'b0, sr, 31, 1'b0, 65535, 4300, 1'b0);
      tr0 = got_q;
      run_walk("b2b_lh", 1'b0, sr, 31, 1'b1, 65535, 4300, 1'b0);
      n_tests++;
      mism = (tr0.size() != got_q.size()) ? 0 : -1;
      if (mism < 0)
        foreach (tr0[i])
          if (got_q[i] !== pack(int'(tr0[i][11:6]), 62 - int'(tr0[i][5:0])) && mism < 0) mism = i;
      if (mism >= 0) begin
        n_fail++;
        $display("FAIL b2b_mirror round %0d: traces diverge at write %0d (sizes %0d/%0d)",
                 round, mism, tr0.size(), got_q.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    int n_we, n_busy;
    build_corridor();
    @(negedge clk);
    hand = 1'b0; srow = 6'd1; scol = 6'd5; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
      if (state_a == S_PROBE_F) hit = 1'b1;
      else @(negedge clk);
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL mid_reset reach_probe_f: state=%0d, want PROBE_F within 40 cycles", state_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({row_a, col_a, oe_a, we_a, busy_a, done_a, fail_a, step_a} !== '0 || state_a !== S_IDLE) begin
      n_fail++;
      $display("FAIL mid_reset async_clear: row=%0d col=%0d oe=%b we=%b busy=%b step=%0d state=%0d, want all 0",
               row_a, col_a, oe_a, we_a, busy_a, step_a, state_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_we = 0; n_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (we_a === 1'b1) n_we++;
      if (busy_a === 1'b1) n_busy++;
    end
    n_tests++;
    if (n_we != 0 || n_busy != 0) begin
      n_fail++;
      $display("FAIL mid_reset quiet: writes=%0d busy_cycles=%0d, want 0 0", n_we, n_busy);
    end
    run_walk("after_reset", 1'b0, 1, 5, 1'b0, 65535, 400, 1'b0);
  endtask

  initial begin
    test_reset();
    test_corridor();
    test_eval_o();
    test_border_start();
    test_wrap();
    test_fail_limit();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_walker.md
# maze_walker

Parametrised wall-follower maze solver. It walks a square maze held in an external synchronous cell memory, marking each visited cell, until it reaches a border cell. It generalises the earlier fixed-width right-hand solver: coordinate width is configurable, right- or left-hand rule is selectable at run time, a start/busy handshake allows repeated solves, and a step counter with timeout reports unsolvable mazes.

## Interface
- `MAZE_W`, default 6: coordinate width; maze is 2^MAZE_W × 2^MAZE_W; border index is 2^MAZE_W−1.
- `STEP_W`, default 16: step counter width.
- `MAX_STEPS`, default 2^STEP_W−1: step limit before `fail`.

- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; accepted only when `busy`=0.
- `hand_sel` in 1: 0 = right-hand rule, 1 = left-hand rule; sampled with `start`.
- `starting_row`, `starting_col` in MAZE_W: start cell; sampled with `start`.
- `maze_in` in 1: read data, 1 = wall, 0 = free; valid the cycle after `maze_oe`.
- `row`, `col` out MAZE_W: cell address for read/write.
- `maze_oe` out 1: synchronous read enable.
- `maze_we` out 1: synchronous write enable; the memory marks the addressed cell visited.
- `busy` out 1: solve in progress.
- `done` out 1: exit reached; held until the next accepted `start`.
- `fail` out 1: step limit hit; held until the next accepted `start`.
- `step_count` out STEP_W: number of moves made in the current or last solve.

## Operation
- All outputs are registered. Reset value of every output is 0. The FSM resets to IDLE, and the direction register resets to DOWN.
- Direction encoding: 0 DOWN (row+1), 1 LEFT (col−1), 2 UP (row−1), 3 RIGHT (col+1).
  - Right turn = dir+1 mod 4. Left turn = dir−1 mod 4. Reverse = dir+2 mod 4.
- Preferred side:
  - Right-hand rule: the preferred side is a right turn and the other side is a left turn.
  - Left-hand rule: the mapping is mirrored.
- FSM states: IDLE, INIT, PROBE_S, EVAL_S, PROBE_F, EVAL_F, PROBE_O, EVAL_O, STEP, DONE, FAIL.
  - IDLE/DONE/FAIL + `start` → INIT. The block latches the coordinates and `hand_sel`, sets dir=DOWN, clears `step_count`/`done`/`fail`, and sets `busy`=1.
  - INIT: `maze_we`=1 at the start cell → PROBE_S.
  - PROBE_x: `maze_oe`=1 with `row`/`col` set to the neighbour in the preferred side, front or other-side direction → EVAL_x.
  - EVAL_S: `maze_in`=0 → dir=preferred side, go to STEP; otherwise → PROBE_F.
  - EVAL_F: `maze_in`=0 → STEP, dir unchanged; otherwise → PROBE_O.
  - EVAL_O: `maze_in`=0 → dir=other side; otherwise dir=reverse. Both cases go to STEP. A dead end always reverses without probing.
  - STEP:
    - Position moves one cell in dir.
    - `maze_we`=1 at the new cell.
    - `step_count` increments.
    - If the new cell has row or col equal to 0 or 2^MAZE_W−1 → DONE (`done`=1, `busy`=0).
    - Else if `step_count`+1 = MAX_STEPS → FAIL (`fail`=1, `busy`=0).
    - Else → PROBE_S.
    - If exit and limit coincide, DONE wins.
- Out-of-range neighbour: this happens when a probe would wrap past 0 or 2^MAZE_W−1, which is only possible when the start is on the border. The block issues no read; PROBE_x asserts `maze_oe`=0, and EVAL_x treats the cell as a wall.
- The border exit check applies only after STEP. A start on the border therefore still walks.
- `start` while `busy`=1 is ignored. `hand_sel` and the coordinates are ignored outside an accepted `start`.
- `maze_oe` and `maze_we` are never asserted in the same cycle. In EVAL, IDLE, DONE and FAIL both are 0, and `row`/`col` hold the current position.

## Timing
- `start` at cycle N → INIT at N+1 (`maze_we` high) → first PROBE_S at N+2.
- Cycles per move:
  - 3 when the preferred side is open.
  - 5 when the front is open.
  - 7 when only the other side is open or at a dead end.
- Read latency is exactly 1: `maze_in` is sampled in the EVAL cycle following PROBE.
- `done`/`fail` rise in the cycle after the final STEP and stay high until the next accepted `start`.
- `rst_n` asserted mid-solve clears everything immediately. No write is issued after reset until a new `start`.

## Structure
- Shared package `maze_pkg`:
  - `dir_t` (2-bit enum) and `state_t` enum.
  - Functions `turn_right`, `turn_left`, `turn_back`.
- Sub-module `maze_neighbour`: combinational. It takes (dir, row, col) and returns the next coordinates plus an `out_of_range` flag, parametrised by MAZE_W. It is instantiated once and its dir input is muxed per state.

## Test plan
- Straight corridor down from (1,5), MAZE_W=6, right hand: 62 moves, exit at row 63 → `done`=1, `step_count`=62, every move takes 5 cycles.
- Single right-angle corridor, start (10,10) facing a wall with only the left side open, right hand: the first move uses EVAL_O, dir becomes RIGHT, and `maze_we` is on (10,11).
- Same maze run twice, with `hand_sel`=0 then `hand_sel`=1 via back-to-back `start`: the write traces differ and mirror each other; `done` clears on the second `start`.
- Closed 3×3 room, MAX_STEPS=20: `fail`=1 after exactly 20 moves, `done`=0, `busy`=0.
- Start at (0,7) on the border with all cells free: no `maze_oe` with row=63 (wrap suppressed), and `done` follows the first STEP onto a border cell.
- Assert `rst_n` low during PROBE_F: all outputs go to 0 asynchronously; after release, no `maze_we` until `start`, and `start` then works normally.
